// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: operating mode, arctangent table generator and the
// uncompensated gain of the micro-rotation chain.
package cordic_pkg;

    typedef enum logic {
        VECTORING = 1'b0,
        ROTATION  = 1'b1
    } mode_e;

    localparam real CORDIC_PI   = 3.14159265358979323846;
    localparam real CORDIC_GAIN = 1.6467602581;

    // atan(2^-idx) in binary angle units (2^(width-1) == pi), rounded to nearest.
    function automatic int atan_angle(input int width, input int idx);
        real a;
        a = $atan(1.0 / (2.0 ** idx)) / CORDIC_PI * (2.0 ** (width - 1));
        return $rtoi(a + 0.5);
    endfunction

endpackage

// File: rtl/cordic_stage.sv
// One CORDIC micro-rotation register stage with fixed shift SHIFT; latency 1 cycle.
// Advances only when en is high (global stall), valid bit is the only reset flop.
module cordic_stage
    import cordic_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHIFT = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             in_vld,
    input  logic             in_mode,
    input  logic [WIDTH+1:0] in_x,
    input  logic [WIDTH+1:0] in_y,
    input  logic [WIDTH-1:0] in_z,
    output logic             out_vld,
    output logic             out_mode,
    output logic [WIDTH+1:0] out_x,
    output logic [WIDTH+1:0] out_y,
    output logic [WIDTH-1:0] out_z
);
    localparam logic [WIDTH-1:0] ATAN = WIDTH'(atan_angle(WIDTH, SHIFT));

    logic [WIDTH+1:0] x_sh, y_sh;
    logic             ccw;
    logic             vld_d, vld_q, mode_d, mode_q;
    logic [WIDTH+1:0] x_d, x_q, y_d, y_q;
    logic [WIDTH-1:0] z_d, z_q;

    always_comb begin
        x_sh   = $signed(in_x) >>> SHIFT;
        y_sh   = $signed(in_y) >>> SHIFT;
        // Vectoring drives y toward zero; rotation drives z toward zero.
        ccw    = (in_mode == ROTATION) ? ~in_z[WIDTH-1] : in_y[WIDTH+1];
        vld_d  = in_vld;
        mode_d = in_mode;
        if (ccw) begin
            x_d = in_x - y_sh;
            y_d = in_y + x_sh;
            z_d = in_z - ATAN;
        end else begin
            x_d = in_x + y_sh;
            y_d = in_y - x_sh;
            z_d = in_z + ATAN;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= 1'b0;
        end else if (en) begin
            vld_q <= vld_d;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            mode_q <= mode_d;
            x_q    <= x_d;
            y_q    <= y_d;
            z_q    <= z_d;
        end
    end

    assign out_vld  = vld_q;
    assign out_mode = mode_q;
    assign out_x    = x_q;
    assign out_y    = y_q;
    assign out_z    = z_q;

endmodule

// File: rtl/cordic_engine.sv
// Pipelined CORDIC (vectoring/rotation): pre-rotation, STAGES micro-rotations, saturating
// output register; latency STAGES+2; whole pipe stalls when m_valid & ~m_ready.
module cordic_engine
    import cordic_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 14
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic               s_mode,
    input  logic [2*WIDTH-1:0] s_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               m_mode,
    output logic [2*WIDTH-1:0] m_data
);
    localparam int               XW     = WIDTH + 2;
    localparam logic [WIDTH-1:0] PI_ANG = {1'b1, {(WIDTH-1){1'b0}}};

    logic             en;
    logic [XW-1:0]    in_x, in_hi;
    logic [WIDTH-1:0] in_z;

    logic             pre_vld_d, pre_vld_q, pre_mode_d, pre_mode_q;
    logic [XW-1:0]    pre_x_d, pre_x_q, pre_y_d, pre_y_q;
    logic [WIDTH-1:0] pre_z_d, pre_z_q;

    logic             vld_a  [0:STAGES];
    logic             mode_a [0:STAGES];
    logic [XW-1:0]    x_a    [0:STAGES];
    logic [XW-1:0]    y_a    [0:STAGES];
    logic [WIDTH-1:0] z_a    [0:STAGES];

    logic               out_vld_d, out_vld_q, out_mode_d, out_mode_q;
    logic [2*WIDTH-1:0] out_dat_d, out_dat_q;

    function automatic logic [WIDTH-1:0] sat_xy(input logic [XW-1:0] v);
        if (v[XW-1:WIDTH-1] == '0 || v[XW-1:WIDTH-1] == '1) begin
            return v[WIDTH-1:0];
        end
        return v[XW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction

    assign en      = ~out_vld_q | m_ready;
    assign s_ready = en;

    // Fold the input into the right half-plane (vectoring) or |z| <= pi/2 (rotation).
    always_comb begin
        in_x       = {{2{s_data[WIDTH-1]}}, s_data[WIDTH-1:0]};
        in_z       = s_data[2*WIDTH-1:WIDTH];
        in_hi      = {{2{in_z[WIDTH-1]}}, in_z};
        pre_vld_d  = s_valid;
        pre_mode_d = s_mode;
        pre_x_d    = in_x;
        pre_y_d    = '0;
        pre_z_d    = in_z;
        if (s_mode == ROTATION) begin
            if (in_z[WIDTH-1] ^ in_z[WIDTH-2]) begin
                pre_x_d = -in_x;
                pre_z_d = in_z + PI_ANG;
            end
        end else begin
            pre_y_d = in_hi;
            pre_z_d = '0;
            if (in_x[XW-1]) begin
                pre_x_d = -in_x;
                pre_y_d = -in_hi;
                pre_z_d = PI_ANG;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_vld_q <= 1'b0;
            out_vld_q <= 1'b0;
        end else if (en) begin
            pre_vld_q <= pre_vld_d;
            out_vld_q <= out_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            pre_mode_q <= pre_mode_d;
            pre_x_q    <= pre_x_d;
            pre_y_q    <= pre_y_d;
            pre_z_q    <= pre_z_d;
            out_mode_q <= out_mode_d;
            out_dat_q  <= out_dat_d;
        end
    end

    assign vld_a[0]  = pre_vld_q;
    assign mode_a[0] = pre_mode_q;
    assign x_a[0]    = pre_x_q;
    assign y_a[0]    = pre_y_q;
    assign z_a[0]    = pre_z_q;

    for (genvar i = 1; i <= STAGES; i++) begin : g_stage
        cordic_stage #(
            .WIDTH (WIDTH),
            .SHIFT (i - 1)
        ) u_stage (
            .clk      (clk),
            .reset_n  (reset_n),
            .en       (en),
            .in_vld   (vld_a[i-1]),
            .in_mode  (mode_a[i-1]),
            .in_x     (x_a[i-1]),
            .in_y     (y_a[i-1]),
            .in_z     (z_a[i-1]),
            .out_vld  (vld_a[i]),
            .out_mode (mode_a[i]),
            .out_x    (x_a[i]),
            .out_y    (y_a[i]),
            .out_z    (z_a[i])
        );
    end

    always_comb begin
        out_vld_d  = vld_a[STAGES];
        out_mode_d = mode_a[STAGES];
        if (mode_a[STAGES] == ROTATION) begin
            out_dat_d = {sat_xy(y_a[STAGES]), sat_xy(x_a[STAGES])};
        end else begin
            out_dat_d = {z_a[STAGES], sat_xy(x_a[STAGES])};
        end
    end

    assign m_valid = out_vld_q;
    assign m_mode  = out_mode_q;
    assign m_data  = out_dat_q;

endmodule

// File: tb/tb_cordic_engine.sv
// Bench for cordic_engine: directed vectors, random mixed-mode traffic with backpressure,
// and mid-flight reset, checked against a real-arithmetic polar/cartesian model.
module tb_cordic_engine;
    localparam int  W   = 16;
    localparam int  N   = 14;
    localparam int  LAT = N + 2;
    localparam real K   = 1.6467602581;
    localparam real PI  = 3.14159265358979323846;

    logic           clk = 1'b0, reset_n = 1'b0;
    logic           s_valid = 1'b0, s_ready, s_mode = 1'b0;
    logic [2*W-1:0] s_data = '0, m_data;
    logic           m_valid, m_ready = 1'b1, m_mode;

    typedef struct {
        logic mode;
        int   hi;
        int   lo;
        int   tol;
        int   acc;
        bit   lat;
    } exp_t;

    exp_t           sb[$];
    int             nchk = 0, nerr = 0, cyc = 0, ready_mode = 0;
    bit             hold_vld = 1'b0;
    logic [2*W-1:0] held_dat;
    logic           held_mode;

    cordic_engine #(.WIDTH(W), .STAGES(N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_mode  (s_mode),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_mode  (m_mode),
        .m_data  (m_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b0;
        endcase
    end

    function automatic int rnd(input real v);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    endfunction

    function automatic int satr(input real v);
        int r;
        r = rnd(v);
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    // Vectoring: magnitude*K and atan2 angle; rotation: K*x rotated by z.
    task automatic model(input logic mode, input int hi, input int lo, output int e_hi, output int e_lo);
        real th;
        if (mode == 1'b0) begin
            e_lo = satr(K * $sqrt(real'(lo) * real'(lo) + real'(hi) * real'(hi)));
            e_hi = rnd($atan2(real'(hi), real'(lo)) / PI * 32768.0) & 32'hFFFF;
        end else begin
            th   = real'(hi) * PI / 32768.0;
            e_hi = satr(K * real'(lo) * $sin(th));
            e_lo = satr(K * real'(lo) * $cos(th));
        end
    endtask

    task automatic chk_eq(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_tol(input string nm, input int act, input int exp, input int tol);
        int d;
        d = act - exp;
        nchk++;
        if (d > tol || d < -tol) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d +/- %0d", nm, act, exp, tol);
        end
    endtask

    task automatic chk_ang(input string nm, input int act, input int exp, input int tol);
        int d;
        d = (act - exp) & 32'hFFFF;
        if (d >= 32768) d -= 65536;
        nchk++;
        if (d > tol || d < -tol) begin
            nerr++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h +/- %0d", nm, act, exp, tol);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            nchk++;
            nerr++;
            $display("FAIL unexpected_beat: got m_data=%h, expected no beat", m_data);
            return;
        end
        e = sb.pop_front();
        chk_eq("mode", int'(m_mode), int'(e.mode));
        if (e.mode == 1'b0) begin
            chk_ang("vec_z", int'(m_data[31:16]), e.hi, e.tol);
            chk_tol("vec_x", int'($signed(m_data[15:0])), e.lo, e.tol);
        end else begin
            chk_tol("rot_y", int'($signed(m_data[31:16])), e.hi, e.tol);
            chk_tol("rot_x", int'($signed(m_data[15:0])), e.lo, e.tol);
        end
        if (e.lat) chk_eq("latency", cyc - e.acc, LAT);
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            hold_vld = 1'b0;
        end else begin
            if (hold_vld) begin
                chk_eq("stall_valid", int'(m_valid), 1);
                chk_eq("stall_data", int'(m_data == held_dat && m_mode == held_mode), 1);
                hold_vld = 1'b0;
            end
            if (m_valid) begin
                if (m_ready) begin
                    check_out();
                end else begin
                    hold_vld  = 1'b1;
                    held_dat  = m_data;
                    held_mode = m_mode;
                end
            end
        end
    end

    // Entered and left at posedge+1 with s_valid low.
    task automatic send_beat(input logic mode, input int hi, input int lo, input bit lat, input int tol);
        exp_t e;
        bit   acc;
        acc     = 1'b0;
        s_valid = 1'b1;
        s_mode  = mode;
        s_data  = {16'(hi), 16'(lo)};
        for (int t = 0; t < 1000 && !acc; t++) begin
            @(negedge clk);
            if (s_ready) begin
                acc    = 1'b1;
                e.mode = mode;
                e.tol  = tol;
                e.acc  = cyc;
                e.lat  = lat;
                model(mode, hi, lo, e.hi, e.lo);
                sb.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        if (!acc) begin
            nchk++;
            nerr++;
            $display("FAIL accept_timeout: s_ready low for 1000 cycles, expected acceptance");
        end
    endtask

    task automatic wait_drain(input int budget);
        for (int t = 0; t < budget && sb.size() != 0; t++) @(posedge clk);
        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            nchk++;
            nerr++;
            $display("FAIL drain_timeout: %0d beats outstanding, expected 0", sb.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  d_mode[7];
        int  d_hi[7];
        int  d_lo[7];
        int  x, y;
        bit  m;
        bit  stale;
        d_mode = '{0, 0, 0, 0, 1, 1, 0};
        d_hi   = '{0, 16384, 0, -8192, 16384, -32768, 32767};
        d_lo   = '{16384, 0, -8192, 0, 8192, 8192, 32767};

        #12;
        chk_eq("reset_m_valid", int'(m_valid), 0);
        chk_eq("reset_s_ready", int'(s_ready), 1);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            send_beat(1'(d_mode[i]), d_hi[i], d_lo[i], 1'b1, 4);
            wait_drain(100);
        end

        // Five beats in flight, output stalled, then reset.
        for (int i = 0; i < 5; i++) send_beat(1'b0, 1000 * i, 12000, 1'b0, 4);
        ready_mode = 2;
        for (int t = 0; t < 60 && !m_valid; t++) @(negedge clk);
        chk_eq("stalled_before_reset", int'(m_valid), 1);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk_eq("async_reset_m_valid", int'(m_valid), 0);
        chk_eq("async_reset_s_ready", int'(s_ready), 1);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n    = 1'b1;
        ready_mode = 0;
        stale      = 1'b0;
        repeat (25) begin
            @(negedge clk);
            stale |= m_valid;
        end
        @(posedge clk);
        #1;
        chk_eq("no_stale_after_reset", int'(stale), 0);
        send_beat(1'b1, 16384, 8192, 1'b1, 4);
        wait_drain(100);

        ready_mode = 1;
        for (int i = 0; i < 256; i++) begin
            while ($urandom_range(0, 1) == 1) begin
                @(posedge clk);
                #1;
            end
            m = 1'($urandom_range(0, 1));
            if (m == 1'b0) begin
                do begin
                    x = int'($urandom_range(0, 32767)) - 16384;
                    y = int'($urandom_range(0, 32767)) - 16384;
                end while (x * x + y * y < 8192 * 8192);
                send_beat(1'b0, y, x, 1'b0, 6);
            end else begin
                y = int'($urandom_range(0, 65535)) - 32768;
                x = int'($urandom_range(0, 12288)) - 6144;
                send_beat(1'b1, y, x, 1'b0, 6);
            end
        end
        wait_drain(5000);
        ready_mode = 0;

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
